// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - round-robin bus arbiter with ownership hold and transaction watchdog
module bus_rr_arbiter #(
    parameter  int NUM_MASTERS = 4,
    parameter  int TIMEOUT     = 64,
    localparam int OWNER_W     = $clog2(NUM_MASTERS),
    localparam int CNT_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] m_req_,
    output logic [NUM_MASTERS-1:0] m_grnt_,
    input  logic                   s_as_,
    input  logic                   s_rdy_,
    output logic [OWNER_W-1:0]     owner,
    output logic                   busy,
    output logic                   to_rdy_,
    output logic                   bus_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [OWNER_W-1:0] LAST_MASTER = OWNER_W'(NUM_MASTERS - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t                   state_q, state_d;
    logic [NUM_MASTERS-1:0]   grnt_q, grnt_d;
    logic [OWNER_W-1:0]       owner_q, owner_d;
    logic [OWNER_W-1:0]       last_q, last_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     busy_q, busy_d;
    logic                     to_rdy_q, to_rdy_d;
    logic                     bus_err_q, bus_err_d;

    logic                     found;
    logic [OWNER_W-1:0]       winner;
    logic [OWNER_W-1:0]       idx;

    // Rotating search: first requester after the last winner, wrapping once around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = last_q;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = (idx == LAST_MASTER) ? '0 : idx + OWNER_W'(1);
            if (!found && !m_req_[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grnt_d    = grnt_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        to_rdy_d  = 1'b1;
        bus_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    grnt_d  = ~(NUM_MASTERS'(1) << winner);
                    owner_d = winner;
                    last_d  = winner;
                end
            end
            GRANT: begin
                // A strobed transaction takes precedence over a simultaneous release.
                if (!s_as_) begin
                    if (s_rdy_) begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end
                end else if (m_req_[owner_q]) begin
                    if (found) begin
                        grnt_d  = ~(NUM_MASTERS'(1) << winner);
                        owner_d = winner;
                        last_d  = winner;
                    end else begin
                        state_d = IDLE;
                        grnt_d  = '1;
                    end
                end
            end
            WAIT: begin
                if (!s_rdy_) begin
                    state_d = GRANT;
                    cnt_d   = '0;
                end else if (TIMEOUT > 0 && cnt_q == CNT_LAST) begin
                    state_d   = GRANT;
                    cnt_d     = '0;
                    to_rdy_d  = 1'b0;
                    bus_err_d = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grnt_d  = '1;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            grnt_q    <= '1;
            owner_q   <= '0;
            last_q    <= LAST_MASTER;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            to_rdy_q  <= 1'b1;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grnt_q    <= grnt_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            to_rdy_q  <= to_rdy_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign m_grnt_ = grnt_q;
    assign owner   = owner_q;
    assign busy    = busy_q;
    assign to_rdy_ = to_rdy_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb/tb_bus_rr_arbiter.sv - self-checking bench for bus_rr_arbiter against a behavioural model
module tb_bus_rr_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic       clk;
    logic       reset;
    logic [3:0] m_req_;
    logic [3:0] m_grnt_;
    logic       s_as_;
    logic       s_rdy_;
    logic [1:0] owner;
    logic       busy;
    logic       to_rdy_;
    logic       bus_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int mdl_owner;
    int mdl_last;
    bit mdl_busy;
    bit mdl_txn;
    int mdl_wait;
    bit mdl_err;

    bus_rr_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset   (reset),
        .m_req_  (m_req_),
        .m_grnt_ (m_grnt_),
        .s_as_   (s_as_),
        .s_rdy_  (s_rdy_),
        .owner   (owner),
        .busy    (busy),
        .to_rdy_ (to_rdy_),
        .bus_err (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        mdl_owner = 0;
        mdl_last  = N - 1;
        mdl_busy  = 0;
        mdl_txn   = 0;
        mdl_wait  = 0;
        mdl_err   = 0;
    endfunction

    function automatic int pick(input logic [3:0] req);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (mdl_last + k) % N;
            if (req[i] == 1'b0) return i;
        end
        return -1;
    endfunction

    function automatic void model_step(input logic [3:0] req, input logic as_, input logic rdy_);
        int w;
        mdl_err = 0;
        if (!mdl_busy) begin
            w = pick(req);
            if (w >= 0) begin
                mdl_busy  = 1;
                mdl_owner = w;
                mdl_last  = w;
            end
        end else if (mdl_txn) begin
            if (rdy_ == 1'b0) mdl_txn = 0;
            else if (mdl_wait == TO - 1) begin
                mdl_txn = 0;
                mdl_err = 1;
            end else mdl_wait++;
        end else if (as_ == 1'b0) begin
            if (rdy_ == 1'b1) begin
                mdl_txn  = 1;
                mdl_wait = 0;
            end
        end else if (req[mdl_owner] == 1'b1) begin
            w = pick(req);
            if (w >= 0) begin
                mdl_owner = w;
                mdl_last  = w;
            end else mdl_busy = 0;
        end
    endfunction

    function automatic logic [8:0] exp_vec();
        logic [3:0] g;
        g = mdl_busy ? ~(4'b0001 << mdl_owner) : 4'b1111;
        return {g, 2'(mdl_owner), mdl_busy, ~mdl_err, mdl_err};
    endfunction

    task automatic tick(input logic [3:0] req, input logic as_, input logic rdy_);
        m_req_ = req;
        s_as_  = as_;
        s_rdy_ = rdy_;
        @(posedge clk);
        model_step(req, as_, rdy_);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        m_req_ = 4'b1111;
        s_as_  = 1'b1;
        s_rdy_ = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({m_grnt_, owner, busy, to_rdy_, bus_err} !== 9'b1111_00_0_1_0) begin
            errors++;
            $display("FAIL reset_state got=%b exp=%b", {m_grnt_, owner, busy, to_rdy_, bus_err}, 9'b1111_00_0_1_0);
        end
        @(negedge clk) reset = 1'b1;
        tick(4'b1110, 1'b1, 1'b1);
        tick(4'b1110, 1'b0, 1'b1);
        repeat (10) tick(4'b1110, 1'b1, 1'b1);
        checks++;
        if ({m_grnt_, owner, busy, to_rdy_, bus_err} !== exp_vec()) begin
            errors++;
            $display("FAIL reset_prewait got=%b exp=%b", {m_grnt_, owner, busy, to_rdy_, bus_err}, exp_vec());
        end
        #2 reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({m_grnt_, busy, bus_err, to_rdy_} !== {4'b1111, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_async got=%b exp=%b", {m_grnt_, busy, bus_err, to_rdy_}, 7'b1111_001);
        end
        @(negedge clk) reset = 1'b1;
        tick(4'b0000, 1'b1, 1'b1);
        checks++;
        if (m_grnt_ !== 4'b1110 || owner !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant got grnt=%b owner=%0d exp grnt=1110 owner=0", m_grnt_, owner);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] rel;
        for (int k = 0; k < 4; k++) begin
            tick(4'b0000, 1'b0, 1'b0);
            checks++;
            if (owner !== 2'(k) || m_grnt_ !== ~(4'b0001 << k)) begin
                errors++;
                $display("FAIL rr_hold k=%0d got owner=%0d grnt=%b exp owner=%0d", k, owner, m_grnt_, k);
            end
            rel = 4'b0001 << k;
            tick(rel, 1'b1, 1'b1);
            checks++;
            if (owner !== 2'((k + 1) % 4) || busy !== 1'b1 || !$onehot(~m_grnt_)) begin
                errors++;
                $display("FAIL rr_handover k=%0d got owner=%0d grnt=%b busy=%b exp owner=%0d", k, owner, m_grnt_, busy, (k + 1) % 4);
            end
            checks++;
            if ({m_grnt_, owner, busy, to_rdy_, bus_err} !== exp_vec()) begin
                errors++;
                $display("FAIL rr_model k=%0d got=%b exp=%b", k, {m_grnt_, owner, busy, to_rdy_, bus_err}, exp_vec());
            end
        end
    endtask

    task automatic test_hold_wrap();
        for (int pass = 0; pass < 2; pass++) begin
            tick(4'b1111, 1'b1, 1'b1);
            tick(4'b1011, 1'b1, 1'b1);
            for (int c = 0; c < 20; c++) begin
                tick(4'b1001, 1'b1, 1'b1);
                checks++;
                if (m_grnt_ !== 4'b1011 || owner !== 2'd2) begin
                    errors++;
                    $display("FAIL hold_owner pass=%0d c=%0d got grnt=%b owner=%0d exp grnt=1011", pass, c, m_grnt_, owner);
                end
            end
            tick((pass == 0) ? 4'b0101 : 4'b1101, 1'b1, 1'b1);
            checks++;
            if (m_grnt_ !== ((pass == 0) ? 4'b0111 : 4'b1101)) begin
                errors++;
                $display("FAIL hold_next pass=%0d got grnt=%b exp=%b", pass, m_grnt_, (pass == 0) ? 4'b0111 : 4'b1101);
            end
        end
    endtask

    task automatic test_watchdog();
        int err_at;
        int err_cnt;
        err_at  = -1;
        err_cnt = 0;
        tick(4'b1111, 1'b1, 1'b1);
        tick(4'b1110, 1'b1, 1'b1);
        tick(4'b1110, 1'b0, 1'b1);
        for (int n = 1; n <= 18; n++) begin
            tick(4'b1110, 1'b1, 1'b1);
            if (bus_err === 1'b1) begin
                err_cnt++;
                if (err_at < 0) err_at = n;
            end
            checks++;
            if ({m_grnt_, owner, busy, to_rdy_, bus_err} !== exp_vec()) begin
                errors++;
                $display("FAIL wd_model n=%0d got=%b exp=%b", n, {m_grnt_, owner, busy, to_rdy_, bus_err}, exp_vec());
            end
        end
        checks++;
        if (err_at != TO || err_cnt != 1) begin
            errors++;
            $display("FAIL wd_timing got at=%0d pulses=%0d exp at=%0d pulses=1", err_at, err_cnt, TO);
        end
        tick(4'b1110, 1'b0, 1'b0);
        tick(4'b1110, 1'b1, 1'b1);
        checks++;
        if (busy !== 1'b1 || m_grnt_ !== 4'b1110 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL wd_back_to_grant got grnt=%b busy=%b err=%b exp grnt=1110 busy=1 err=0", m_grnt_, busy, bus_err);
        end
    endtask

    task automatic test_slave_beats();
        tick(4'b1110, 1'b0, 1'b1);
        repeat (15) tick(4'b1110, 1'b1, 1'b1);
        tick(4'b1110, 1'b1, 1'b0);
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (bus_err !== 1'b0 || to_rdy_ !== 1'b1 || {m_grnt_, owner, busy, to_rdy_, bus_err} !== exp_vec()) begin
                errors++;
                $display("FAIL slave_beats n=%0d got err=%b to_rdy_=%b vec=%b exp=%b", n, bus_err, to_rdy_, {m_grnt_, owner, busy, to_rdy_, bus_err}, exp_vec());
            end
            tick(4'b1110, 1'b1, 1'b1);
        end
    endtask

    task automatic test_release_wait();
        int         o;
        logic [3:0] rel;
        tick(4'b1111, 1'b1, 1'b1);
        tick(4'b0000, 1'b1, 1'b1);
        o   = mdl_owner;
        rel = 4'b0001 << o;
        tick(4'b0000, 1'b0, 1'b1);
        tick(4'b0000, 1'b1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            tick(rel, 1'b1, 1'b1);
            checks++;
            if (m_grnt_ !== ~rel || owner !== 2'(o)) begin
                errors++;
                $display("FAIL rel_hold c=%0d got grnt=%b exp=%b", c, m_grnt_, ~rel);
            end
        end
        tick(rel, 1'b1, 1'b0);
        checks++;
        if (m_grnt_ !== ~rel || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL rel_ready got grnt=%b err=%b exp grnt=%b err=0", m_grnt_, bus_err, ~rel);
        end
        tick(rel, 1'b1, 1'b1);
        checks++;
        if (owner !== 2'((o + 1) % 4) || m_grnt_ !== ~(4'b0001 << ((o + 1) % 4))) begin
            errors++;
            $display("FAIL rel_next got owner=%0d grnt=%b exp owner=%0d", owner, m_grnt_, (o + 1) % 4);
        end
    endtask

    task automatic test_random();
        logic [3:0] req;
        logic       as_;
        logic       rdy_;
        int         mode;
        req  = 4'b1111;
        mode = 0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) mode = 1 - mode;
            as_  = ($urandom_range(0, 3) != 0);
            rdy_ = (mode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
            tick(req, as_, rdy_);
            checks++;
            if ({m_grnt_, owner, busy, to_rdy_, bus_err} !== exp_vec()) begin
                errors++;
                $display("FAIL random c=%0d got=%b exp=%b", c, {m_grnt_, owner, busy, to_rdy_, bus_err}, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_hold_wrap();
        test_watchdog();
        test_slave_beats();
        test_release_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
